// File: rtl/link_pkg.sv
// Shared definitions for the 4-phase req/ack link (responder and master).
package link_pkg;

  localparam int LINK_DATA_W = 8;

  // Responder handshake FSM encodings
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACKED = 1'b1
  } link_state_t;

  // Phases of one 4-phase transaction as seen on the {req, ack} wire pair
  typedef enum logic [1:0] {
    PH_REST    = 2'b00,  // req=0 ack=0
    PH_REQUEST = 2'b10,  // req=1 ack=0
    PH_ACCEPT  = 2'b11,  // req=1 ack=1
    PH_RELEASE = 2'b01   // req=0 ack=1
  } link_phase_t;

endpackage

// File: rtl/link_fifo.sv
// Synchronous FIFO with registered pointers and occupancy; head is read from storage.
module link_fifo
  import link_pkg::*;
#(
  parameter int DATA_W = LINK_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // A pop from empty is dropped; a push into full only succeeds alongside a pop.
  assign do_rd   = rd_en && (level != '0);
  assign do_wr   = wr_en && ((level != FULL_LVL) || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; contents are only meaningful below the occupancy mark.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/link_rx_buffer.sv
// Responder end of the 4-phase req/ack link, buffering received words for a valid/ready consumer.
//
//   state    | meaning
//   ST_IDLE  | ack low, waiting for req with room in the buffer
//   ST_ACKED | word captured, ack high until master drops req
module link_rx_buffer
  import link_pkg::*;
#(
  parameter int DATA_W = LINK_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [DATA_W-1:0]        data,
  output logic                     ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               rx_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  link_state_t state;
  logic        pop;
  logic        push_ok;
  logic        capture;

  // A full buffer still accepts a word when the consumer frees a slot on the same edge.
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign push_ok   = (level != FULL_LVL) || pop;
  assign capture   = (state == ST_IDLE) && req && push_ok;

  link_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (data),
    .rd_en   (pop),
    .rd_data (out_data),
    .level   (level)
  );

  // Handshake FSM with registered ack and the accepted-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ack      <= 1'b0;
      rx_count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            state    <= ST_ACKED;
            ack      <= 1'b1;
            rx_count <= rx_count + 8'd1;
          end
        end
        ST_ACKED: begin
          if (!req) begin
            state <= ST_IDLE;
            ack   <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_rx_buffer.sv
// Directed bench for link_rx_buffer (DATA_W=8, DEPTH=4).
module tb_link_rx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] data;
  logic       ack;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] level;
  logic [7:0] rx_count;

  int total = 0;
  int bad   = 0;

  link_rx_buffer #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .rx_count  (rx_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Complete one transfer with out_ready held low; ack must rise and then fall.
  task automatic push_word(input logic [7:0] w, input string name);
    req = 1'b1; data = w;
    tick();
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL %s ack_rise: got %b want 1", name, ack); end
    req = 1'b0;
    tick();
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL %s ack_fall: got %b want 0", name, ack); end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ack, out_valid, level, rx_count} !== 13'd0) begin
      bad++;
      $display("FAIL reset_state: got ack=%b vld=%b lvl=%0d cnt=%0d want all 0", ack, out_valid, level, rx_count);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    req = 1'b1; data = 8'hA5;
    tick();
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL single_ack_rise: got %b want 1", ack); end
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      bad++; $display("FAIL single_out: got vld=%b data=%h want 1 a5", out_valid, out_data);
    end
    total++;
    if (rx_count !== 8'd1) begin bad++; $display("FAIL single_rx_count: got %0d want 1", rx_count); end
    req = 1'b0;
    tick();
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL single_ack_fall: got %b want 0", ack); end
    total++;
    if (level !== 3'd0) begin bad++; $display("FAIL single_popped: got level=%0d want 0", level); end
  endtask

  task automatic test_burst();
    logic [7:0] exp_q [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    out_ready = 1'b0;
    push_word(8'h11, "burst0");
    push_word(8'h22, "burst1");
    push_word(8'h33, "burst2");
    push_word(8'h44, "burst3");
    total++;
    if (level !== 3'd4) begin bad++; $display("FAIL burst_full: got level=%0d want 4", level); end
    req = 1'b1; data = 8'h55;
    tick(); tick(); tick();
    total++;
    if (ack !== 1'b0 || level !== 3'd4) begin
      bad++; $display("FAIL burst_stall: got ack=%b lvl=%0d want 0 4", ack, level);
    end
    total++;
    if (out_data !== 8'h11) begin bad++; $display("FAIL burst_head: got %h want 11", out_data); end
    out_ready = 1'b1;
    tick();
    total++;
    if (ack !== 1'b1 || level !== 3'd4 || out_data !== 8'h22) begin
      bad++; $display("FAIL burst_unstall: got ack=%b lvl=%0d head=%h want 1 4 22", ack, level, out_data);
    end
    total++;
    if (rx_count !== 8'd6) begin bad++; $display("FAIL burst_rx_count: got %0d want 6", rx_count); end
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
        bad++; $display("FAIL burst_drain%0d: got vld=%b data=%h want 1 %h", i, out_valid, out_data, exp_q[i]);
      end
      tick();
    end
    total++;
    if (level !== 3'd0 || ack !== 1'b0) begin
      bad++; $display("FAIL burst_empty: got lvl=%0d ack=%b want 0 0", level, ack);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q [4] = '{8'h62, 8'h63, 8'h64, 8'h65};
    out_ready = 1'b0;
    push_word(8'h61, "full0");
    push_word(8'h62, "full1");
    push_word(8'h63, "full2");
    push_word(8'h64, "full3");
    out_ready = 1'b1; req = 1'b1; data = 8'h65;
    tick();
    total++;
    if (ack !== 1'b1 || level !== 3'd4 || out_data !== 8'h62) begin
      bad++; $display("FAIL full_pushpop: got ack=%b lvl=%0d head=%h want 1 4 62", ack, level, out_data);
    end
    out_ready = 1'b0; req = 1'b0;
    tick();
    total++;
    if (ack !== 1'b0 || level !== 3'd4) begin
      bad++; $display("FAIL full_release: got ack=%b lvl=%0d want 0 4", ack, level);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_data !== exp_q[i]) begin
        bad++; $display("FAIL full_drain%0d: got %h want %h", i, out_data, exp_q[i]);
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL full_empty: got vld=%b want 0", out_valid); end
  endtask

  task automatic test_held_req();
    do_reset();
    out_ready = 1'b0;
    req = 1'b1; data = 8'h3C;
    tick();
    repeat (10) tick();
    total++;
    if (level !== 3'd1 || rx_count !== 8'd1 || ack !== 1'b1) begin
      bad++; $display("FAIL held_single: got lvl=%0d cnt=%0d ack=%b want 1 1 1", level, rx_count, ack);
    end
    total++;
    if (out_data !== 8'h3C) begin bad++; $display("FAIL held_data: got %h want 3c", out_data); end
    req = 1'b0;
    tick();
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL held_ack_fall: got %b want 0", ack); end
    out_ready = 1'b1;
    tick();
    total++;
    if (level !== 3'd0) begin bad++; $display("FAIL held_drain: got lvl=%0d want 0", level); end
  endtask

  task automatic test_wrap();
    logic [7:0] w;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      w = 8'(i);
      req = 1'b1; data = w;
      tick();
      total++;
      if (ack !== 1'b1 || out_valid !== 1'b1 || out_data !== w) begin
        bad++; $display("FAIL wrap%0d: got ack=%b vld=%b data=%h want 1 1 %h", i, ack, out_valid, out_data, w);
      end
      req = 1'b0;
      tick();
    end
    total++;
    if (rx_count !== 8'd44) begin bad++; $display("FAIL wrap_rx_count: got %0d want 44", rx_count); end
    total++;
    if (level !== 3'd0) begin bad++; $display("FAIL wrap_level: got %0d want 0", level); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    push_word(8'h01, "arst0");
    req = 1'b1; data = 8'h02;
    tick();
    total++;
    if (ack !== 1'b1 || level !== 3'd2) begin
      bad++; $display("FAIL arst_setup: got ack=%b lvl=%0d want 1 2", ack, level);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({ack, out_valid, level, rx_count} !== 13'd0) begin
      bad++;
      $display("FAIL arst_immediate: got ack=%b vld=%b lvl=%0d cnt=%0d want all 0", ack, out_valid, level, rx_count);
    end
    req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    req = 1'b1; data = 8'h7E;
    tick();
    total++;
    if (ack !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h7E || rx_count !== 8'd1) begin
      bad++;
      $display("FAIL arst_after: got ack=%b vld=%b data=%h cnt=%0d want 1 1 7e 1", ack, out_valid, out_data, rx_count);
    end
    req = 1'b0;
    tick();
    total++;
    if (ack !== 1'b0 || level !== 3'd0) begin
      bad++; $display("FAIL arst_after_fall: got ack=%b lvl=%0d want 0 0", ack, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_pop();
    test_held_req();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/link_rx_buffer.md
# link_rx_buffer

Responder end of the 4-phase req/ack link. It receives words from a link master over the req/data/ack handshake and buffers them in a small FIFO. It presents them to a downstream consumer on a valid/ready port. It withholds ack while the buffer is full, so back-pressure on the consumer side stalls the master.

## Interface
Parameters:
- DATA_W, 8, width of a link word
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  master request; data is valid while req=1
- data  in  DATA_W  master data
- ack  out  1  4-phase acknowledge
- out_valid  out  1  buffer has a word for the consumer
- out_ready  in  1  consumer accepts the head word
- out_data  out  DATA_W  head-of-FIFO word
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- rx_count  out  8  accepted words, wraps 255→0

## Operation
- The handshake FSM has two states: IDLE and ACKED. It resets to IDLE.
- Transition IDLE→ACKED on the sampled condition req=1 and push_ok.
  - push_ok = (level<DEPTH) or (out_valid and out_ready) in the same cycle.
  - On that edge: `data` is written to the FIFO tail, ack goes to 1, and rx_count increments.
- If req=1 but not push_ok, stay in IDLE with ack=0. No data is captured and the request stays pending.
- ACKED holds ack=1 while req=1.
- Transition ACKED→IDLE when req=0 is sampled. ack goes to 0 on that edge.
- Each req pulse captures exactly one word. A req that stays high in ACKED never causes a second capture.
- Pop: on an edge with out_valid=1 and out_ready=1, the head is removed.
- out_valid = (level!=0).
- out_data is the head entry. It is stable while out_valid=1 and no pop occurs.
- Simultaneous push and pop:
  - level is unchanged.
  - When full, the push is allowed because a slot frees on the same edge.
- Pop when empty: ignored. level stays 0.
- Pointers wrap modulo DEPTH.
- rx_count wraps modulo 256.
- Reset values: ack=0, out_valid=0, level=0, rx_count=0, FSM=IDLE, pointers=0.
  - out_data after reset is don't-care; it is only valid with out_valid.
- Reset mid-transfer:
  - Buffered words are discarded and ack drops immediately (asynchronous).
  - After release, if req is still 1, the block treats it as a new request and captures again.
  - The master is responsible for that case.

## Timing
- req→ack latency: ack rises on the first rising edge where req=1 and push_ok hold. That is 1 cycle when not full.
- ack fall: 1 edge after req is sampled low.
- Capture→out_valid: out_valid rises on the same edge as ack. There is no bypass path beyond the registered FIFO write.
- Minimum full transaction (req↑ ack↑ req↓ ack↓) is 4 edges, given a master that reacts in one cycle.
- Full stall: ack rises on the edge where a pop frees a slot, or on that same edge via the simultaneous push/pop rule.
- All outputs are registered or derived only from registered state. There is no combinational req→ack path.

## Structure
- The shared header link_pkg holds:
  - the default DATA_W;
  - the FSM state encodings (IDLE=0, ACKED=1);
  - the ack/req phase definitions, reused by the link master.
- Sub-module link_fifo: a synchronous FIFO with parameters DATA_W and DEPTH.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, level.
- link_rx_buffer contains the handshake FSM, the rx_count counter, and the push_ok logic.

## Test plan
- Single transfer, out_ready=1: master sends 0xA5.
  - ack rises 1 edge after req.
  - out_valid=1 with out_data=0xA5.
  - ack falls 1 edge after req drops.
  - rx_count=1.
- Burst, out_ready=0: master sends 0x11, 0x22, 0x33, 0x44 (DEPTH=4). Required responses:
  - All four are acked and level=4.
  - A fifth req (0x55) sees ack held at 0.
  - Raising out_ready pops 0x11, and on that edge ack rises with 0x55 captured.
  - Drain order is 0x22, 0x33, 0x44, 0x55.
- Full plus simultaneous pop: with level=4, out_ready=1 and req=1 rise together.
  - Push and pop occur on the same edge and level stays 4.
- Held req: req stays high for 10 cycles after ack.
  - Exactly one word is captured, level=1 and rx_count=1.
- Wrap: 300 transfers of data=i[7:0] with out_ready=1.
  - Output sequence matches input with no loss.
  - rx_count=44.
  - The pointers wrap many times.
- Async reset mid-transfer: assert rst with ack=1 and level=2, between clock edges.
  - ack, out_valid, level and rx_count go to 0 immediately.
  - After release with req=0, the next transfer of 0x7E behaves as in the single-transfer case.
